// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encoding and sizing constants for the EX-stage divider
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ZERO,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    localparam int DIV_ITER     = 32;
    localparam int DIV_RESULT_W = 2 * DIV_ITER;

endpackage

// File: rtl/div_unit_step.sv
// div_step: one restoring-division iteration (shift, trial subtract, quotient bit)
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]  rq_i,
    input  logic [DATA_W-1:0]  dvs_i,
    output logic [2*DATA_W:0]  rq_o
);

    logic [2*DATA_W:0] sh;
    logic [DATA_W+1:0] diff;

    // an extra sign bit on the difference tells whether the partial remainder covers the divisor
    always_comb begin
        sh   = rq_i << 1;
        diff = {1'b0, sh[2*DATA_W:DATA_W]} - {2'b0, dvs_i};
        rq_o = diff[DATA_W+1] ? sh
                              : {diff[DATA_W:0], sh[DATA_W-1:0] | {{(DATA_W-1){1'b0}}, 1'b1}};
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider that stalls EX during DIV/DIVU
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_ITER,
    parameter int ITER_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_signed,
    input  logic [DATA_W-1:0]     i_dividend,
    input  logic [DATA_W-1:0]     i_divisor,
    input  logic                  i_annul,
    output logic                  o_stall_req,
    output logic                  o_ready,
    output logic [2*DATA_W-1:0]   o_result
);

    localparam logic [ITER_W-1:0] LAST = ITER_W'(DATA_W - 1);

    div_state_t          state_q;
    logic [ITER_W-1:0]   cnt_q;
    logic [2*DATA_W:0]   rq_q;
    logic [2*DATA_W:0]   rq_d;
    logic [DATA_W-1:0]   dvs_q;
    logic                negq_q;
    logic                negr_q;
    logic [2*DATA_W-1:0] result_q;
    logic [2*DATA_W-1:0] result_d;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W-1:0]   q_mag;
    logic [DATA_W-1:0]   r_mag;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rq_i  (rq_q),
        .dvs_i (dvs_q),
        .rq_o  (rq_d)
    );

    // operand magnitudes for latching, and sign-corrected result of the final iteration
    always_comb begin
        a_neg    = i_signed & i_dividend[DATA_W-1];
        b_neg    = i_signed & i_divisor[DATA_W-1];
        a_mag    = a_neg ? -i_dividend : i_dividend;
        b_mag    = b_neg ? -i_divisor : i_divisor;
        q_mag    = rq_d[DATA_W-1:0];
        r_mag    = rq_d[2*DATA_W-1:DATA_W];
        result_d = {negr_q ? -r_mag : r_mag, negq_q ? -q_mag : q_mag};
    end

    // stall and ready are combinational so that an annul kills them in the same cycle
    always_comb begin
        o_stall_req = i_rst_n && !i_annul &&
                      ((state_q == DIV_IDLE && i_start) || state_q == DIV_ZERO || state_q == DIV_BUSY);
        o_ready     = !i_annul && state_q == DIV_DONE;
        o_result    = result_q;
    end

    // control FSM and iteration datapath; the result register only changes on entry to DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rq_q     <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else if (i_annul) begin
            state_q <= DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (i_start && i_divisor == '0) begin
                        state_q <= DIV_ZERO;
                    end else if (i_start) begin
                        state_q <= DIV_BUSY;
                        cnt_q   <= '0;
                        rq_q    <= {{(DATA_W+1){1'b0}}, a_mag};
                        dvs_q   <= b_mag;
                        negq_q  <= a_neg ^ b_neg;
                        negr_q  <= a_neg;
                    end
                end
                DIV_ZERO: begin
                    state_q  <= DIV_DONE;
                    result_q <= '0;
                end
                DIV_BUSY: begin
                    rq_q  <= rq_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q  <= DIV_DONE;
                        result_q <= result_d;
                    end
                end
                DIV_DONE: state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for the EX-stage divider
module tb_div_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_signed = 1'b0;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic        i_annul = 1'b0;
    logic        o_stall_req;
    logic        o_ready;
    logic [63:0] o_result;

    int n_cmp = 0;
    int n_err = 0;

    div_unit dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_signed    (i_signed),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .i_annul     (i_annul),
        .o_stall_req (o_stall_req),
        .o_ready     (o_ready),
        .o_result    (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; that cycle is cycle 0. Returns just after the
    // rising edge that ends DONE, with i_start still high.
    task automatic run(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int exp_lat, input int exp_stall);
        int lat = -1;
        int st = 0;
        logic [63:0] res = '0;
        i_signed = sg;
        i_dividend = a;
        i_divisor = b;
        i_start = 1'b1;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            @(negedge i_clk);
            if (o_stall_req) st++;
            if (o_ready) begin
                lat = c;
                res = o_result;
            end
            @(posedge i_clk);
            #1;
            if (c == 0) begin
                i_dividend = ~a;
                i_divisor = b ^ 32'h5;
                i_signed = ~sg;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_stall"}, 64'(st), 64'(exp_stall));
        chk({tag, "_res"}, res, exp);
    endtask

    task automatic idle(input string tag);
        i_start = 1'b0;
        @(negedge i_clk);
        chk({tag, "_rdy1"}, 64'(o_ready), 64'd0);
        chk({tag, "_stl"}, 64'(o_stall_req), 64'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic no_ready(input string tag, input int cycles);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge i_clk);
            if (o_ready) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #23;
        chk("rst_stall", 64'(o_stall_req), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_result", o_result, 64'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        run("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 33);
        idle("divu_100_7");

        run("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 33);
        run("b2b_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, {32'h2, 32'hFFFFFFF2}, 33, 33);
        idle("b2b");

        run("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 33);
        idle("div_min_m1");
        run("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33, 33);
        idle("divu_max_1");
        run("divu_3_10", 1'b0, 32'd3, 32'd10, {32'h3, 32'h0}, 33, 33);
        idle("divu_3_10");

        run("divzero", 1'b0, 32'd5, 32'd0, 64'd0, 2, 2);
        idle("divzero");

        i_signed = 1'b0;
        i_dividend = 32'd50;
        i_divisor = 32'd5;
        i_start = 1'b1;
        repeat (10) begin
            @(posedge i_clk);
            #1;
        end
        i_annul = 1'b1;
        @(negedge i_clk);
        chk("annul_busy_stall", 64'(o_stall_req), 64'd0);
        chk("annul_busy_ready", 64'(o_ready), 64'd0);
        @(posedge i_clk);
        #1;
        i_annul = 1'b0;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("annul_then_idle", 64'(o_stall_req), 64'd0);
        @(posedge i_clk);
        #1;
        no_ready("annul_no_ready", 40);
        run("divu_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33, 33);
        idle("divu_9_3");

        i_dividend = 32'd20;
        i_divisor = 32'd4;
        i_start = 1'b1;
        repeat (33) begin
            @(posedge i_clk);
            #1;
        end
        i_annul = 1'b1;
        @(negedge i_clk);
        chk("annul_done_ready", 64'(o_ready), 64'd0);
        chk("annul_done_stall", 64'(o_stall_req), 64'd0);
        @(posedge i_clk);
        #1;
        i_annul = 1'b0;
        i_start = 1'b0;
        no_ready("annul_done_after", 3);

        i_annul = 1'b1;
        i_start = 1'b1;
        @(negedge i_clk);
        chk("annul_idle_stall", 64'(o_stall_req), 64'd0);
        @(posedge i_clk);
        #1;
        i_annul = 1'b0;
        i_start = 1'b0;

        i_dividend = 32'd1000;
        i_divisor = 32'd3;
        i_start = 1'b1;
        repeat (15) begin
            @(posedge i_clk);
            #1;
        end
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", 64'(o_stall_req), 64'd0);
        chk("rst_mid_ready", 64'(o_ready), 64'd0);
        chk("rst_mid_result", o_result, 64'd0);
        i_start = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        no_ready("rst_mid_no_ready", 40);
        chk("rst_mid_result_hold", o_result, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
